// File: rtl/eda_s2p_rx.sv
// Serial-to-parallel receiver: hunts an MSB-first bit stream for SYNC, then deserialises frames of SYNC + WORDS bytes.
// Latency: each data byte appears on dout_o, with a one-cycle dvld_o pulse, in the cycle after its LSB is sampled.
// Backpressure: none. The consumer must take each byte on its dvld_o pulse because the serial line cannot be stalled.
//
// Ports:
//   clk_i    sole clock; din_i is sampled on the rising edge, one bit per cycle
//   rst_n_i  asynchronous active-low reset
//   din_i    serial data, MSB of each byte first
//   dout_o   last received data byte; holds until the next byte arrives
//   dvld_o   one-cycle pulse: dout_o was updated this cycle
//   lock_o   high while frame-aligned
//   err_o    one-cycle pulse: the inter-frame sync check failed and lock was lost
//
// Build option FRAME_CHK_EN: when defined, the SYNC byte between frames is verified,
// and a mismatch drops lock and pulses err_o. When undefined, that byte slot is skipped
// without checking, err_o is tied low, and lock_o stays high from first lock until reset.

module eda_s2p_rx #(
    parameter logic [7:0]  SYNC  = 8'hE4,
    parameter int unsigned WORDS = 4       // data bytes per frame, 1..255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       din_i,
    output logic [7:0] dout_o,
    output logic       dvld_o,
    output logic       lock_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        S_HUNT,
        S_LOCK,
        S_CHECK
    } state_e;

    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

    state_e     state_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] word_cnt_q;
    logic [7:0] dout_q;
    logic       dvld_q;
    logic       lock_q;
    logic       err_q;

    // The byte that ends with the bit sampled at this edge.
    assign sr_d = {sr_q[6:0], din_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_HUNT;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            word_cnt_q <= 8'd0;
            dout_q     <= 8'h00;
            dvld_q     <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            dvld_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // Bit-sliding search: every edge is a candidate byte boundary.
                S_HUNT: begin
                    if (sr_d == SYNC) begin
                        state_q    <= S_LOCK;
                        lock_q     <= 1'b1;
                        bit_cnt_q  <= 3'd0;
                        word_cnt_q <= 8'd0;
                    end
                end
                // A SYNC-valued byte here is ordinary data; alignment is
                // only revisited in the sync slot between frames.
                S_LOCK: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        dout_q <= sr_d;
                        dvld_q <= 1'b1;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_q <= 8'd0;
                            state_q    <= S_CHECK;
                        end else begin
                            word_cnt_q <= word_cnt_q + 8'd1;
                        end
                    end
                end
                // Sync slot between frames. bit_cnt wrapped to 0 on the last
                // data byte, so it counts this slot from its first bit.
                S_CHECK: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef FRAME_CHK_EN
                        if (sr_d == SYNC) begin
                            state_q <= S_LOCK;
                        end else begin
                            // Hunting resumes with the next bit; the history
                            // in sr_q is kept so the search keeps sliding.
                            state_q <= S_HUNT;
                            lock_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
`else
                        state_q <= S_LOCK;
`endif
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout_o = dout_q;
    assign dvld_o = dvld_q;
    assign lock_o = lock_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_eda_s2p_rx.sv
// Bench for eda_s2p_rx: directed byte table, hand-written reset sequence, and a randomised
// stream. A frame-position reference model checks every cycle; the table gives the expected
// value at each byte's LSB.

module tb_eda_s2p_rx;

    localparam logic [7:0] SYNC_B  = 8'hE4;
    localparam int         WORDS_N = 4;
    localparam int         PERIOD  = (WORDS_N + 1) * 8;   // bits per frame including SYNC

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout;
    logic       dvld;
    logic       lock;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    eda_s2p_rx #(.SYNC(SYNC_B), .WORDS(WORDS_N)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .din_i   (din),
        .dout_o  (dout),
        .dvld_o  (dvld),
        .lock_o  (lock),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the last 8 line bits and, once locked, the
    // bit position within the repeating frame.
    logic [7:0] m_last8;
    logic       m_locked;
    int         m_k;          // bits received since the SYNC that produced lock
    logic       exp_dvld;
    logic [7:0] exp_dout;
    logic       exp_err;

    task automatic model_reset();
        m_last8  = 8'h00;
        m_locked = 1'b0;
        m_k      = 0;
        exp_dvld = 1'b0;
        exp_dout = 8'h00;
        exp_err  = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        int p;
        m_last8  = {m_last8[6:0], b};
        exp_dvld = 1'b0;
        exp_err  = 1'b0;
        if (!m_locked) begin
            if (m_last8 == SYNC_B) begin
                m_locked = 1'b1;
                m_k      = 0;
            end
        end else begin
            m_k = m_k + 1;
            p   = (m_k - 1) % PERIOD;
            if (p < WORDS_N * 8) begin
                if (p % 8 == 7) begin
                    exp_dvld = 1'b1;
                    exp_dout = m_last8;
                end
            end else if (p == PERIOD - 1) begin
`ifdef FRAME_CHK_EN
                if (m_last8 != SYNC_B) begin
                    m_locked = 1'b0;
                    exp_err  = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One bit on the line, followed by a full compare against the model.
    task automatic step(input logic b);
        din = b;
        @(posedge clk);
        #1;
        model_edge(b);
        chk("cyc_dvld", {7'd0, dvld}, {7'd0, exp_dvld});
        chk("cyc_dout", dout, exp_dout);
        chk("cyc_lock", {7'd0, lock}, {7'd0, m_locked});
        chk("cyc_err",  {7'd0, err},  {7'd0, exp_err});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       dvld;
        logic [7:0] dout;
        logic       lock;
        logic       err;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic [7:0] d, input logic v, input logic [7:0] o,
                       input logic l, input logic e);
        vec_t r;
        r.din = d; r.dvld = v; r.dout = o; r.lock = l; r.err = e;
        tab.push_back(r);
    endtask

    initial begin
        logic [7:0] rb;
        int         n;

        model_reset();

        // Acquire: E4 then four data bytes.
        add(8'hE4, 1'b0, 8'h00, 1'b1, 1'b0);
        add(8'h11, 1'b1, 8'h11, 1'b1, 1'b0);
        add(8'h22, 1'b1, 8'h22, 1'b1, 1'b0);
        add(8'h33, 1'b1, 8'h33, 1'b1, 1'b0);
        add(8'h44, 1'b1, 8'h44, 1'b1, 1'b0);
        // Two back-to-back frames.
        add(8'hE4, 1'b0, 8'h44, 1'b1, 1'b0);
        add(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);
        add(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0);
        add(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        add(8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        add(8'hE4, 1'b0, 8'h00, 1'b1, 1'b0);
        add(8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        add(8'h02, 1'b1, 8'h02, 1'b1, 1'b0);
        add(8'h03, 1'b1, 8'h03, 1'b1, 1'b0);
        add(8'h04, 1'b1, 8'h04, 1'b1, 1'b0);
        // Data bytes equal to SYNC.
        add(8'hE4, 1'b0, 8'h04, 1'b1, 1'b0);
        add(8'hE4, 1'b1, 8'hE4, 1'b1, 1'b0);
        add(8'hE4, 1'b1, 8'hE4, 1'b1, 1'b0);
        add(8'hE4, 1'b1, 8'hE4, 1'b1, 1'b0);
        add(8'hE4, 1'b1, 8'hE4, 1'b1, 1'b0);
`ifdef FRAME_CHK_EN
        // Bad sync byte: lock drops with an error pulse, then E4 re-locks.
        add(8'hE5, 1'b0, 8'hE4, 1'b0, 1'b1);
        add(8'hE4, 1'b0, 8'hE4, 1'b1, 1'b0);
`else
        // Unchecked sync slot: garbage is skipped, lock held.
        add(8'h00, 1'b0, 8'hE4, 1'b1, 1'b0);
`endif
        add(8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
        add(8'h20, 1'b1, 8'h20, 1'b1, 1'b0);
        add(8'h30, 1'b1, 8'h30, 1'b1, 1'b0);
        add(8'h40, 1'b1, 8'h40, 1'b1, 1'b0);
        add(8'hE4, 1'b0, 8'h40, 1'b1, 1'b0);
        add(8'h55, 1'b1, 8'h55, 1'b1, 1'b0);
        add(8'hAA, 1'b1, 8'hAA, 1'b1, 1'b0);
        add(8'h12, 1'b1, 8'h12, 1'b1, 1'b0);
        add(8'h34, 1'b1, 8'h34, 1'b1, 1'b0);

        // Reset state, before any clock edge.
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_dvld", {7'd0, dvld}, 8'h00);
        chk("rst_lock", {7'd0, lock}, 8'h00);
        chk("rst_err",  {7'd0, err},  8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three junk bits, then the table.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        foreach (tab[i]) begin
            send_byte(tab[i].din);
            chk("vec_dvld", {7'd0, dvld}, {7'd0, tab[i].dvld});
            chk("vec_dout", dout, tab[i].dout);
            chk("vec_lock", {7'd0, lock}, {7'd0, tab[i].lock});
            chk("vec_err",  {7'd0, err},  {7'd0, tab[i].err});
        end

        // Reset mid-byte must clear outputs without waiting for a clock edge.
        step(1'b0);
        step(1'b1);
        step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_dvld", {7'd0, dvld}, 8'h00);
        chk("arst_lock", {7'd0, lock}, 8'h00);
        chk("arst_err",  {7'd0, err},  8'h00);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b0);
        chk("idle_lock", {7'd0, lock}, 8'h00);

        // Random mix of junk bits, junk bytes, good frames and corrupted syncs.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 7);
                    for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)));
                end
                3: begin
                    rb = 8'($urandom_range(0, 255));
                    send_byte(rb);
                end
                default: begin
                    if ($urandom_range(0, 5) == 0)
                        send_byte(SYNC_B ^ 8'($urandom_range(1, 255)));
                    else
                        send_byte(SYNC_B);
                    for (int j = 0; j < WORDS_N; j++) begin
                        rb = 8'($urandom_range(0, 255));
                        send_byte(rb);
                    end
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
